// File: rtl/distance_tone_mapper.sv
// Distance-to-tone mapper: moving average of distance samples, clamp, linear map to half-period, square-wave tone.
// Optional macro DIST_MUTE_EN: mute the tone after MUTE_TIMEOUTS consecutive timeout samples.
module distance_tone_mapper #(
  parameter int LOG_N         = 3,
  parameter int MIN_MM        = 50,
  parameter int MAX_MM        = 800,
  parameter int HP_MIN        = 50000,
  parameter int HP_STEP       = 250,
  parameter int MUTE_TIMEOUTS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dist_valid,
  input  logic [31:0] dist_mm,
  input  logic        flush,
  input  logic        tone_en,
  output logic [15:0] avg_mm,
  output logic        avg_valid,
  output logic        primed,
  output logic [23:0] half_period,
  output logic [7:0]  timeout_cnt,
  output logic        muted,
  output logic        tone_out
);

  localparam int N  = 1 << LOG_N;
  localparam int SW = 16 + LOG_N;

`ifdef DIST_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic [15:0]      ring [N];
  logic [SW-1:0]    sum;
  logic [LOG_N:0]   fill;
  logic [LOG_N-1:0] wr_ptr;
  logic             s1_valid;
  logic             is_timeout;
  logic             take;
  logic [15:0]      clamped;
  logic [15:0]      avg_next;
  logic [23:0]      hp_next;
  logic [23:0]      hp_cur;
  logic [23:0]      tone_cnt;
  logic             active;

  assign is_timeout = (dist_mm == 32'hFFFF_FFFF);
  assign take       = dist_valid && !is_timeout && !flush;
  assign primed     = (fill == (LOG_N+1)'(N));
  assign muted      = MUTE_EN && (timeout_cnt >= 8'(MUTE_TIMEOUTS));
  assign active     = tone_en && primed && !muted;

  // Full 32-bit compare so values above 16 bits still clamp to MAX_MM.
  always_comb begin
    clamped = dist_mm[15:0];
    if (dist_mm < 32'(MIN_MM))
      clamped = 16'(MIN_MM);
    else if (dist_mm > 32'(MAX_MM))
      clamped = 16'(MAX_MM);
  end

  assign avg_next = sum[SW-1:LOG_N];
  assign hp_next  = 24'(HP_MIN) + (24'(avg_next) - 24'(MIN_MM)) * 24'(HP_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      for (int i = 0; i < N; i++) ring[i] <= '0;
      sum         <= '0;
      fill        <= '0;
      wr_ptr      <= '0;
      s1_valid    <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      s1_valid <= take;
      if (dist_valid && is_timeout) begin
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
      end else if (take) begin
        timeout_cnt  <= '0;
        ring[wr_ptr] <= clamped;
        sum          <= sum + SW'(clamped) - SW'(ring[wr_ptr]);
        wr_ptr       <= wr_ptr + 1'b1;
        if (!primed) fill <= fill + 1'b1;
      end
    end
  end

  // Stage 2 uses the fill count already advanced by stage 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      avg_mm      <= '0;
      half_period <= '0;
      avg_valid   <= 1'b0;
    end else begin
      avg_valid <= s1_valid && primed;
      if (s1_valid && primed) begin
        avg_mm      <= avg_next;
        half_period <= hp_next;
      end
    end
  end

  // hp_cur is latched only at toggles so a new pitch never cuts a half-cycle short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_out <= 1'b0;
      tone_cnt <= '0;
      hp_cur   <= '0;
    end else if (!active) begin
      tone_out <= 1'b0;
      tone_cnt <= '0;
      hp_cur   <= half_period;
    end else if (hp_cur == '0) begin
      hp_cur <= half_period;
    end else if (tone_cnt == hp_cur - 24'd1) begin
      tone_out <= ~tone_out;
      tone_cnt <= '0;
      hp_cur   <= half_period;
    end else begin
      tone_cnt <= tone_cnt + 24'd1;
    end
  end

endmodule

// File: tb/tb_distance_tone_mapper.sv
// Directed bench: default-parameter instance for mapping values, short half-period instance for tone timing.
module tb_distance_tone_mapper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dist_valid = 1'b0;
  logic [31:0] dist_mm = '0;
  logic        flush = 1'b0;
  logic        tone_en = 1'b0;

  logic [15:0] avg_mm, avg_mm_t;
  logic        avg_valid, avg_valid_t;
  logic        primed, primed_t;
  logic [23:0] half_period, half_period_t;
  logic [7:0]  timeout_cnt, timeout_cnt_t;
  logic        muted, muted_t;
  logic        tone_out, tone_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int av_cnt = 0;
  int snap;
  int e0, e1, e2, e3;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avg_valid) av_cnt <= av_cnt + 1;
  end

  distance_tone_mapper dut (
    .clk(clk), .reset(reset), .dist_valid(dist_valid), .dist_mm(dist_mm),
    .flush(flush), .tone_en(tone_en), .avg_mm(avg_mm), .avg_valid(avg_valid),
    .primed(primed), .half_period(half_period), .timeout_cnt(timeout_cnt),
    .muted(muted), .tone_out(tone_out)
  );

  // hp = 20 + (avg - 50): 400 mm -> 370, 450 mm -> 420, 612 mm -> 582
  distance_tone_mapper #(.HP_MIN(20), .HP_STEP(1)) dut_t (
    .clk(clk), .reset(reset), .dist_valid(dist_valid), .dist_mm(dist_mm),
    .flush(flush), .tone_en(tone_en), .avg_mm(avg_mm_t), .avg_valid(avg_valid_t),
    .primed(primed_t), .half_period(half_period_t), .timeout_cnt(timeout_cnt_t),
    .muted(muted_t), .tone_out(tone_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    dist_valid = 1'b1;
    dist_mm    = v;
    tick();
    dist_valid = 1'b0;
  endtask

  task automatic wait_edge(output int at);
    logic p;
    p = tone_t;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (tone_t != p) begin
        at = cyc;
        return;
      end
    end
    check("tone_edge_timeout", 0, 1);
    at = cyc;
  endtask

  initial begin
    tick(); tick();
    check("rst_avg_mm", avg_mm, 0);
    check("rst_half_period", half_period, 0);
    check("rst_primed", primed, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    check("rst_muted", muted, 0);
    check("rst_tone_out", tone_out, 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) send(400);
    check("prime_7_not_primed", primed, 0);
    send(400);
    check("prime_8_primed", primed, 1);
    check("prime_8_no_valid_yet", avg_valid, 0);
    tick();
    check("prime_avg_valid_t2", avg_valid, 1);
    check("prime_avg_mm", avg_mm, 400);
    check("prime_half_period", half_period, 137500);
    check("prime_half_period_t", half_period_t, 370);
    tick();
    check("prime_avg_valid_one_cycle", avg_valid, 0);

    tone_en = 1'b1;
    wait_edge(e0);
    wait_edge(e1);
    wait_edge(e2);
    check("tone_spacing_a", e1 - e0, 370);
    check("tone_spacing_b", e2 - e1, 370);

    send(800);
    tick();
    check("wrap_avg_mm", avg_mm, 450);
    check("wrap_half_period", half_period, 150000);
    wait_edge(e3);
    check("phase_old_period_kept", e3 - e2, 370);
    wait_edge(e0);
    check("phase_new_period", e0 - e3, 420);

    snap = av_cnt;
    for (int k = 0; k < 4; k++) send(32'hFFFF_FFFF);
    check("to_cnt_4", timeout_cnt, 4);
`ifdef DIST_MUTE_EN
    check("to_muted", muted, 1);
    tick();
    check("to_tone_silent", tone_t, 0);
`else
    check("to_not_muted", muted, 0);
    wait_edge(e1);
`endif
    for (int k = 0; k < 252; k++) send(32'hFFFF_FFFF);
    check("to_cnt_saturate", timeout_cnt, 255);
    check("to_avg_mm_held", avg_mm, 450);
    tick();
    check("to_no_avg_valid", av_cnt - snap, 0);
    send(400);
    check("to_cleared", timeout_cnt, 0);
    check("to_unmuted", muted, 0);
    tick();
    check("to_resume_avg_mm", avg_mm, 450);

    for (int k = 0; k < 8; k++) send(20);
    tick();
    check("clamp_low_avg", avg_mm, 50);
    check("clamp_low_hp", half_period, 50000);
    for (int k = 0; k < 8; k++) send(2000);
    tick();
    check("clamp_high_avg", avg_mm, 800);
    check("clamp_high_hp", half_period, 237500);
    for (int k = 0; k < 8; k++) send(70000);
    tick();
    check("clamp_wide_avg", avg_mm, 800);
    check("clamp_wide_hp", half_period, 237500);

    send(500);
    flush = 1'b1;
    dist_valid = 1'b1;
    dist_mm = 300;
    tick();
    flush = 1'b0;
    dist_valid = 1'b0;
    check("flush_avg_valid_suppressed", avg_valid, 0);
    check("flush_primed", primed, 0);
    check("flush_avg_mm", avg_mm, 0);
    check("flush_half_period", half_period, 0);
    tick();
    check("flush_tone_off", tone_t, 0);

    snap = av_cnt;
    for (int k = 1; k <= 10; k++) begin
      dist_valid = 1'b1;
      dist_mm = 32'(100 * k);
      tick();
      if (k == 7) check("b2b_7_not_primed", primed, 0);
      if (k == 8) check("b2b_8_primed", primed, 1);
    end
    dist_valid = 1'b0;
    tick();
    check("b2b_avg_mm", avg_mm, 612);
    check("b2b_half_period", half_period, 190500);
    check("b2b_half_period_t", half_period_t, 582);
    tick();
    check("b2b_pulses", av_cnt - snap, 3);

    wait_edge(e0);
    #3 reset = 1'b1;
    #1;
    check("async_rst_avg_mm", avg_mm, 0);
    check("async_rst_primed", primed, 0);
    check("async_rst_hp", half_period, 0);
    check("async_rst_tone", tone_t, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/distance_tone_mapper.md
Name: distance_tone_mapper

Overview:
- Downstream consumer of the ultrasonic distance measurement stage in the theremin datapath.
- Accepts per-measurement distance samples in mm and rejects timeout codes.
- Smooths samples with a 2^LOG_N moving average, clamps to the playable range, and maps the result linearly to a tone half-period.
- Drives a phase-continuous square-wave audio output to the speaker/PWM pin.

Parameters:
LOG_N, 3, log2 of moving-average depth (8 samples)
MIN_MM, 50, nearest playable distance in mm (highest pitch)
MAX_MM, 800, farthest playable distance in mm (lowest pitch)
HP_MIN, 50000, half-period in clk cycles at MIN_MM (1 kHz at 100 MHz)
HP_STEP, 250, half-period cycles added per mm above MIN_MM
MUTE_TIMEOUTS, 4, consecutive timeouts that mute the tone (only with DIST_MUTE_EN)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
dist_valid  in  1  single-cycle strobe: dist_mm holds a new measurement
dist_mm  in  32  distance in mm; 32'hFFFFFFFF means timeout
flush  in  1  synchronous clear of the averaging history
tone_en  in  1  tone output enable
avg_mm  out  16  clamped moving-average distance
avg_valid  out  1  one-cycle pulse when avg_mm/half_period update
primed  out  1  history full (N valid samples since reset/flush)
half_period  out  24  current mapped half-period in clk cycles
timeout_cnt  out  8  consecutive timeout count, saturates at 255
muted  out  1  tone muted by timeouts (0 without DIST_MUTE_EN)
tone_out  out  1  square-wave audio

Behaviour:
- Reset: all outputs 0; ring buffer, running sum, fill count, write pointer, and tone counter 0.
- Timeout sample (dist_valid and dist_mm==32'hFFFFFFFF):
  - Not written to history. timeout_cnt increments, saturating at 255.
  - avg_valid stays low.
- Valid sample:
  - timeout_cnt cleared.
  - Value clamped to [MIN_MM, MAX_MM] as 16 bits.
  - Clamp compares the full 32 bits: any value >MAX_MM (including values ≥2^16) becomes MAX_MM.
- Pipeline stage 1 (cycle after dist_valid):
  - Clamped value written at wr_ptr.
  - sum <= sum + new - buf[wr_ptr] (the oldest entry). sum width is 16+LOG_N bits, so it never overflows.
  - wr_ptr increments and wraps modulo 2^LOG_N.
  - fill count increments, saturating at 2^LOG_N.
- Pipeline stage 2:
  - avg_mm <= sum >> LOG_N.
  - half_period <= HP_MIN + (avg_mm_new - MIN_MM) * HP_STEP, computed in 24 bits.
  - avg_valid pulses only if primed.
  - Latency: dist_valid at cycle t gives avg_valid at t+2.
  - Back-to-back dist_valid every cycle is accepted; there is no backpressure.
- primed = (fill count == 2^LOG_N). Before primed, avg_mm and half_period hold 0.
- flush:
  - Clears buffer, sum, fill, wr_ptr, primed, avg_mm, half_period, and timeout_cnt next cycle.
  - Flush together with dist_valid: flush wins and the sample is dropped. In-flight stage-2 update is suppressed.
- Tone generator:
  - Active when tone_en && primed && !muted.
  - When active, a 24-bit counter counts 0..half_period-1, then toggles tone_out and reloads 0.
  - A new half_period takes effect only at the next toggle, keeping phase continuous.
  - When inactive: tone_out=0 and counter=0 on the next cycle.
- Reset mid-operation: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: DIST_MUTE_EN.
- Defined:
  - muted=1 when timeout_cnt >= MUTE_TIMEOUTS; tone_out forced 0 and counter cleared.
  - muted clears on the first valid sample.
  - History is unaffected, so the tone resumes with the existing average.
- Undefined: muted tied 0; timeouts never affect the tone; timeout_cnt still reported.

Test Plan:
- Reset, then 8 valid samples of 400 → primed=1 after the 8th.
  - avg_valid at t+2 of the 8th sample.
  - avg_mm=400, half_period=137500.
  - With tone_en=1, tone_out toggles every 137500 cycles.
- Clamping:
  - 8 samples of 20 → avg_mm=50, half_period=50000.
  - 8 samples of 2000 (and 8 of 70000) → avg_mm=800, half_period=237500.
- Wrap/running sum: after 8×400, one sample of 800 → avg_mm=450, half_period=150000; tone_out edge spacing changes only at the next toggle.
- Timeouts with DIST_MUTE_EN:
  - After priming, 4 timeout samples → timeout_cnt=4, muted=1, tone_out=0; avg_mm unchanged.
  - Next valid sample 400 → muted=0, timeout_cnt=0.
  - Without the macro: muted stays 0 and the tone continues.
- flush asserted the same cycle as dist_valid=1 (dist_mm=300) → sample dropped; primed=0, avg_mm=0, tone_out=0; 8 new samples are needed to re-prime.
- Back-to-back dist_valid for 10 consecutive cycles with values 100..1000 step 100 → 3 avg_valid pulses (samples 8–10); final avg_mm=(300+400+500+600+700+800+800+800)/8=612.
